// File: rtl/cm_frame_regbank_if.sv
// Bus between the CM detector / control logic and the frame register bank.
// Latency: n/a (wiring only).
// Backpressure: none; the detector side is strobe-driven and cannot be stalled.
interface cm_frame_regbank_if #(
  parameter int DATA_W = 16,
  parameter int FCNT_W = 16
);
  logic              cs;
  logic [DATA_W-1:0] data_in;
  logic [7:0]        d_number;
  logic [7:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_valid;
  logic [FCNT_W-1:0] frame_cnt;
  logic              err_seq;
  logic              err_timeout;
  logic              busy;

  modport master (
    output cs, data_in, d_number, rd_addr,
    input  rd_data, frame_valid, frame_cnt, err_seq, err_timeout, busy
  );

  modport slave (
    input  cs, data_in, d_number, rd_addr,
    output rd_data, frame_valid, frame_cnt, err_seq, err_timeout, busy
  );
endinterface

// File: rtl/cm_frame_regbank.sv
// Collects CM frame words into a shadow bank and commits whole in-order frames by bank swap.
// Latency: word acted on 3 clk after cs rises; frame_valid 1 clk after final word; rd_data 1 clk after rd_addr.
// Backpressure: none; out-of-order or stalled frames are dropped with an error pulse.
module cm_frame_regbank #(
  parameter int REG_MAX        = 50,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FCNT_W         = 16
) (
  input logic clk,
  input logic rst_n,
  cm_frame_regbank_if.slave bus
);

  localparam int AW = (REG_MAX > 1) ? $clog2(REG_MAX) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    LAST_IDX = 8'(REG_MAX);
  // Timer holds T-2 in the last cycle before expiry; a quiet cycle there fires the timeout.
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  state_t            state, state_nx;
  logic [7:0]        expected, expected_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic              cs_s1, cs_s2, cs_s3;
  logic              stb;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic              seq_err, to_err, commit_go;
  logic              active, have_frame;
  logic              shadow_sel;
  logic [FCNT_W-1:0] fcnt_q;
  logic [DATA_W-1:0] bank [2][REG_MAX];

  assign stb        = cs_s2 & ~cs_s3;
  assign shadow_sel = ~active;
  assign bus.frame_cnt = fcnt_q;

  // Bring cs into the clk domain and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1 <= 1'b0;
      cs_s2 <= 1'b0;
      cs_s3 <= 1'b0;
    end else begin
      cs_s1 <= bus.cs;
      cs_s2 <= cs_s1;
      cs_s3 <= cs_s2;
    end
  end

  // FSM state, expected index and inter-word timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      expected <= '0;
      timer    <= '0;
    end else begin
      state    <= state_nx;
      expected <= expected_nx;
      timer    <= timer_nx;
    end
  end

  // Next state: frame start/restart, in-order accept, sequence error, timeout.
  always_comb begin
    state_nx    = state;
    expected_nx = expected;
    timer_nx    = timer;
    wr_en       = 1'b0;
    wr_addr     = '0;
    seq_err     = 1'b0;
    to_err      = 1'b0;
    commit_go   = 1'b0;
    case (state)
      RECV: begin
        if (stb) begin
          if (bus.d_number == expected) begin
            wr_en       = 1'b1;
            wr_addr     = AW'(expected - 8'd1);
            expected_nx = expected + 8'd1;
            timer_nx    = '0;
            if (expected == LAST_IDX) begin
              state_nx  = COMMIT;
              commit_go = 1'b1;
            end
          end else if (bus.d_number == 8'd1) begin
            // Detector resynced on a fresh 'CM' header: start over quietly.
            wr_en       = 1'b1;
            wr_addr     = '0;
            expected_nx = 8'd2;
            timer_nx    = '0;
          end else begin
            seq_err  = 1'b1;
            state_nx = IDLE;
          end
        end else if (timer == TMO_LAST) begin
          to_err   = 1'b1;
          state_nx = IDLE;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: begin
        // IDLE and COMMIT treat a strobe identically; non-header words are ignored.
        state_nx = IDLE;
        if (stb && bus.d_number == 8'd1) begin
          wr_en       = 1'b1;
          wr_addr     = '0;
          expected_nx = 8'd2;
          timer_nx    = '0;
          if (REG_MAX == 1) begin
            state_nx  = COMMIT;
            commit_go = 1'b1;
          end else begin
            state_nx  = RECV;
          end
        end
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.busy        = (state == RECV);
    bus.frame_valid = (state == COMMIT);
  end

  // Commit bookkeeping (swap happens on entry to COMMIT so reads that cycle see the new frame) and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active          <= 1'b0;
      have_frame      <= 1'b0;
      fcnt_q          <= '0;
      bus.err_seq     <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.err_seq     <= seq_err;
      bus.err_timeout <= to_err;
      if (commit_go) begin
        active     <= ~active;
        have_frame <= 1'b1;
        fcnt_q     <= fcnt_q + FCNT_W'(1);
      end
    end
  end

  // Bank storage: only the shadow bank is ever written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < REG_MAX; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      bank[shadow_sel][wr_addr] <= bus.data_in;
    end
  end

  // Registered read of the committed bank; zero before the first frame or out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
    end else if (have_frame && bus.rd_addr < LAST_IDX) begin
      bus.rd_data <= bank[active][bus.rd_addr[AW-1:0]];
    end else begin
      bus.rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_cm_frame_regbank.sv
// Randomised frame stimulus against a queue-based frame model; events and reads scoreboarded.
// Latency: checks strobe-to-event cycle counts and 1-cycle read latency.
// Backpressure: n/a.
module tb_cm_frame_regbank;
  localparam int REG_MAX = 50;
  localparam int DW      = 16;
  localparam int FW      = 16;
  localparam int TO      = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cm_frame_regbank_if #(.DATA_W(DW), .FCNT_W(FW)) bus();

  cm_frame_regbank #(
    .REG_MAX(REG_MAX), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .FCNT_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event kinds: 1 frame_valid, 2 err_seq, 4 err_timeout.
  typedef struct {int kind; int cyc; int cnt;} ev_t;
  ev_t evq[$];
  int  rdq[$];
  logic rd_en = 1'b0;
  logic rd_pend;
  wire [2:0] obs = {bus.err_timeout, bus.err_seq, bus.frame_valid};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_en;
  end

  // Reference model: a frame is the list of words collected so far.
  int partial[$];
  bit in_frame = 0;
  int committed[REG_MAX];
  bit have = 0;
  int fcnt = 0;
  int last_rise = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name, int a, int b);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, b, cyc);
  endfunction

  function automatic void push_ev(int kind, int c, int cnt);
    ev_t e;
    e.kind = kind; e.cyc = c; e.cnt = cnt;
    evq.push_back(e);
  endfunction

  function automatic void model_reset();
    partial.delete();
    in_frame = 0; have = 0; fcnt = 0;
    foreach (committed[i]) committed[i] = 0;
  endfunction

  function automatic int model_read(int a);
    return (have && a < REG_MAX) ? committed[a] : 0;
  endfunction

  function automatic void model_word(int idx, int w, int rise);
    if (idx == 1) begin
      partial.delete();
      partial.push_back(w);
      in_frame = 1;
    end else if (in_frame && idx == partial.size() + 1) begin
      partial.push_back(w);
    end else if (in_frame) begin
      push_ev(2, rise + 3, 0);
      in_frame = 0;
    end
    if (in_frame && partial.size() == REG_MAX) begin
      for (int i = 0; i < REG_MAX; i++) committed[i] = partial[i];
      have = 1;
      fcnt = (fcnt + 1) % (1 << FW);
      push_ev(1, rise + 3, fcnt);
      in_frame = 0;
    end
  endfunction

  task automatic do_read(int a);
    bus.rd_addr = 8'(a);
    rd_en = 1'b1;
    rdq.push_back(model_read(a));
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // One cs pulse (4 high); a random read lands in the cycle after the strobe; next rise is gap cycles later.
  task automatic pulse(int idx, int w, int gap = 8);
    bus.d_number = 8'(idx);
    bus.data_in  = 16'(w);
    last_rise = cyc;
    model_word(idx, w, cyc);
    bus.cs = 1'b1;
    repeat (3) @(negedge clk);
    do_read($urandom_range(0, 55));
    bus.cs = 1'b0;
    repeat (gap - 4) @(negedge clk);
  endtask

  // mode 0: constant fill, 1: header then 0x1000+(k-1), 2: random.
  task automatic send_range(int lo, int hi, int mode, int fill);
    int w;
    for (int k = lo; k <= hi; k++) begin
      if (mode == 0)      w = fill;
      else if (mode == 1) w = (k == 1) ? 16'h4D43 : 16'h1000 + k - 1;
      else                w = $urandom_range(0, 65535);
      pulse(k, w);
    end
  endtask

  task automatic expect_timeout();
    push_ev(4, last_rise + TO + 2, 0);
    partial.delete();
    in_frame = 0;
  endtask

  // Monitor: pop an expected event whenever the DUT pulses, and an expected word on each read return.
  always @(negedge clk) begin
    if (rst_n) begin
      if (obs != 3'b000) begin
        if (evq.size() == 0) begin
          fail_now("unexpected_event", int'(obs), 0);
        end else begin
          chk("event_kind", obs, evq[0].kind);
          chk("event_cycle", cyc, evq[0].cyc);
          if (evq[0].kind == 1) chk("event_frame_cnt", bus.frame_cnt, evq[0].cnt);
          void'(evq.pop_front());
        end
      end else if (evq.size() != 0 && cyc > evq[0].cyc) begin
        fail_now("missing_event", 0, evq[0].kind);
        void'(evq.pop_front());
      end
      if (rd_pend) begin
        if (rdq.size() == 0) begin
          fail_now("orphan_read", int'(bus.rd_data), -1);
        end else begin
          chk("rd_data", bus.rd_data, rdq[0]);
          void'(rdq.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b0; bus.data_in = '0; bus.d_number = '0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_frame_valid", bus.frame_valid, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_err_seq", bus.err_seq, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame.
    send_range(1, REG_MAX, 1, 0);
    chk("clean_cnt", bus.frame_cnt, fcnt);
    do_read(0); do_read(49); do_read(50);

    // Atomicity: partial frame B must not disturb committed frame A.
    send_range(1, REG_MAX, 0, 16'hAAAA);
    send_range(1, 30, 0, 16'hBBBB);
    chk("partial_busy", bus.busy, 1);
    for (int a = 0; a < REG_MAX; a++) do_read(a);
    send_range(31, REG_MAX, 0, 16'hBBBB);
    for (int a = 0; a < REG_MAX; a += 7) do_read(a);
    chk("atomic_cnt", bus.frame_cnt, fcnt);

    // Sequence error.
    send_range(1, 10, 2, 0);
    pulse(12, $urandom_range(0, 65535));
    chk("seq_busy", bus.busy, 0);
    for (int a = 0; a < REG_MAX; a += 5) do_read(a);
    chk("seq_cnt", bus.frame_cnt, fcnt);

    // Resync on a new header mid-frame.
    send_range(1, 20, 2, 0);
    send_range(1, REG_MAX, 2, 0);
    for (int a = 0; a < REG_MAX; a += 3) do_read(a);

    // Timeout after silence.
    send_range(1, 5, 2, 0);
    expect_timeout();
    repeat (110) @(negedge clk);
    chk("timeout_busy", bus.busy, 0);

    // Strobe exactly on the expiry cycle wins.
    send_range(1, 4, 2, 0);
    pulse(5, $urandom_range(0, 65535), TO - 1);
    send_range(6, REG_MAX, 2, 0);
    for (int a = 0; a < REG_MAX; a += 6) do_read(a);

    // Strobe one cycle after expiry is too late and is ignored in IDLE.
    send_range(1, 5, 2, 0);
    expect_timeout();
    repeat (TO - 8) @(negedge clk);
    pulse(6, $urandom_range(0, 65535));
    chk("late_busy", bus.busy, 0);

    // Random frames with occasional corrupted indices.
    repeat (4) begin
      for (int k = 1; k <= REG_MAX; k++) begin
        int idx;
        idx = ($urandom_range(0, 31) == 0) ? int'($urandom_range(1, 60)) : k;
        pulse(idx, $urandom_range(0, 65535));
      end
    end
    chk("random_cnt", bus.frame_cnt, fcnt);

    // Reset mid-frame.
    send_range(1, 10, 2, 0);
    rst_n = 1'b0;
    model_reset();
    evq.delete();
    rdq.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_rd_data", bus.rd_data, 0);
    chk("mid_rst_frame_cnt", bus.frame_cnt, 0);
    chk("mid_rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 56; a += 5) do_read(a);
    send_range(1, REG_MAX, 1, 0);
    for (int a = 0; a < 56; a += 4) do_read(a);
    chk("post_rst_cnt", bus.frame_cnt, fcnt);

    repeat (4) @(negedge clk);
    chk("events_left", evq.size(), 0);
    chk("reads_left", rdq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
